// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared constants for the iterative divider and pipeline control
package div_iter_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

    localparam logic DIV_START  = 1'b1;
    localparam logic DIV_STOP   = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff;

    assign shifted = {rem_i, bit_i};
    // Extra top bit of diff is the borrow; no borrow means the divisor fits.
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
    assign q_o     = ~diff[WIDTH+1];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_diff = diff[WIDTH];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring divider with sign fix-up, early exit and dbz flag
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             dbz_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_out_q, dbz_out_d;
    logic             done_q, done_d;

    logic             dvd_is_neg, dvs_is_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign dvd_is_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_is_neg = signed_i & divisor_i[WIDTH-1];
    assign dvd_abs    = dvd_is_neg ? -dividend_i : dividend_i;
    assign dvs_abs    = dvs_is_neg ? -divisor_i  : divisor_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (prem_q),
        .dvs_i (dvs_q),
        .bit_i (dvd_q[WIDTH-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dbz_d     = dbz_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        quot_d    = quot_q;
        rem_out_d = rem_out_q;
        dbz_out_d = dbz_out_q;
        done_d    = DIV_STOP;

        case (state_q)
            DIV_IDLE: begin
                if (start_i == DIV_START && !annul_i) begin
                    sgn_d     = signed_i;
                    dvd_neg_d = dvd_is_neg;
                    dvs_neg_d = dvs_is_neg;
                    dvs_d     = dvs_abs;
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    quo_d     = '0;
                    prem_d    = '0;
                    if (divisor_i == '0) begin
                        dbz_d   = 1'b1;
                        state_d = DIV_FIX;
                    end else if (EARLY_EXIT != 0 && dvd_abs < dvs_abs) begin
                        prem_d  = dvd_abs;
                        state_d = DIV_FIX;
                    end else begin
                        dvd_d   = dvd_abs;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (annul_i) begin
                    cnt_d   = '0;
                    state_d = DIV_IDLE;
                end else begin
                    // Dividend bits are consumed MSB first by shifting left.
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                    prem_d = step_rem;
                    quo_d  = {quo_q[WIDTH-2:0], step_q};
                    if (cnt_q == LAST_STEP) begin
                        cnt_d   = '0;
                        state_d = DIV_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                if (!annul_i) begin
                    if (dbz_q) begin
                        quot_d    = '0;
                        rem_out_d = '0;
                    end else begin
                        quot_d    = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
                        rem_out_d = (sgn_q & dvd_neg_q) ? -prem_q : prem_q;
                    end
                    dbz_out_d = dbz_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            quot_q    <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dbz_q     <= dbz_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
            done_q    <= done_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_out_q;
    assign dbz_o  = dbz_out_q;
    assign done_o = done_q;
    assign busy_o = (state_q != DIV_IDLE);

endmodule
